// File: rtl/sccb_config_master.sv
// rtl/sccb_config_master.sv - walks the camera register ROM, one SCCB 3-phase write per entry
// 16'hFFF0 entries become a bus-idle delay; the run ends when the ROM reports finished.
module sccb_config_master #(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned SCCB_HZ      = 100_000,
   parameter logic [7:0]  DEV_ID       = 8'h42,
   parameter int unsigned DELAY_CYCLES = 500_000,
   parameter int unsigned SETTLE       = 3
) (
   input  logic        clk_50,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] command,
   input  logic        finished,
   output logic        rom_resend,
   output logic        advance,
   output logic        sioc,
   output logic        siod_o,
   output logic        siod_oe,
   output logic        busy,
   output logic        done
);
   localparam int unsigned Q_RAW = CLK_HZ / (4 * SCCB_HZ);
   localparam int unsigned Q     = (Q_RAW < 1) ? 1 : Q_RAW;
   localparam int unsigned QW    = (Q > 1) ? $clog2(Q) : 1;

   typedef enum logic [3:0] {
      IDLE, REWIND, SETTLE_W, CHECK, START, BITS, STOP, GAP, DELAY, ADV, DONE
   } state_t;

   state_t        state, state_n;
   logic [QW-1:0] q_cnt;
   logic [1:0]    quarter;
   logic [1:0]    last_quarter;
   logic [4:0]    bit_cnt;
   logic [31:0]   dly_cnt;
   logic [26:0]   frame;
   logic          start_d;
   logic          start_rise;
   logic          q_last;
   logic          seg_end;
   logic          dont_care;

   assign start_rise   = start & ~start_d;
   assign q_last       = (q_cnt == QW'(Q - 1));
   assign last_quarter = (state == START) ? 2'd1 : (state == STOP) ? 2'd2 : 2'd3;
   assign seg_end      = q_last && (quarter == last_quarter);
   assign dont_care    = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == 5'd26);

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         q_cnt   <= '0;
         quarter <= '0;
         bit_cnt <= '0;
         dly_cnt <= '0;
         frame   <= '1;
         start_d <= 1'b0;
      end else begin
         state   <= state_n;
         start_d <= start;
         if (state_n != state) begin
            q_cnt   <= '0;
            quarter <= '0;
            dly_cnt <= '0;
         end else begin
            if (state == SETTLE_W || state == DELAY)
               dly_cnt <= dly_cnt + 32'd1;
            if (state inside {START, BITS, STOP, GAP}) begin
               if (q_last) begin
                  q_cnt   <= '0;
                  quarter <= quarter + 2'd1;
               end else begin
                  q_cnt <= q_cnt + QW'(1);
               end
            end
         end
         if (state != BITS)
            bit_cnt <= '0;
         else if (seg_end)
            bit_cnt <= bit_cnt + 5'd1;
         // Don't-care positions are loaded high; siod_oe masks them on the bus.
         if (state == CHECK)
            frame <= {DEV_ID, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
         else if (state == BITS && seg_end)
            frame <= {frame[25:0], 1'b1};
      end
   end

   always_comb begin
      state_n    = state;
      sioc       = 1'b1;
      siod_o     = 1'b1;
      siod_oe    = 1'b1;
      rom_resend = 1'b0;
      advance    = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start_rise) state_n = REWIND;
         end
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start_rise) state_n = REWIND;
         end
         REWIND: begin
            rom_resend = 1'b1;
            state_n    = SETTLE_W;
         end
         SETTLE_W: if (dly_cnt == 32'(SETTLE - 1)) state_n = CHECK;
         // finished is tested first so the FFFF end marker never reaches the bus
         CHECK: begin
            if (finished)                  state_n = DONE;
            else if (command == 16'hFFF0)  state_n = DELAY;
            else                           state_n = START;
         end
         START: begin
            siod_o = 1'b0;
            sioc   = (quarter == 2'd0);
            if (seg_end) state_n = BITS;
         end
         BITS: begin
            sioc    = quarter[1];
            siod_o  = frame[26];
            siod_oe = ~dont_care;
            if (seg_end && bit_cnt == 5'd26) state_n = STOP;
         end
         STOP: begin
            sioc   = (quarter != 2'd0);
            siod_o = (quarter == 2'd2);
            if (seg_end) state_n = GAP;
         end
         GAP:   if (seg_end) state_n = ADV;
         DELAY: if (dly_cnt == 32'(DELAY_CYCLES - 1)) state_n = ADV;
         ADV: begin
            advance = 1'b1;
            state_n = SETTLE_W;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_sccb_config_master.sv
// tb/tb_sccb_config_master.sv - randomized bench: ROM model, SCCB bus monitor, frame/timing reference
`timescale 1ns/1ps
module tb_sccb_config_master;
   localparam int CLK_HZ    = 800_000;
   localparam int SCCB_HZ   = 100_000;
   localparam int DLY       = 20;
   localparam int SETTLE    = 3;
   localparam int Q         = CLK_HZ / (4 * SCCB_HZ);
   localparam int WRITE_GAP = 1 + SETTLE + 1 + 117 * Q;
   localparam int DELAY_GAP = 1 + SETTLE + 1 + DLY;
   localparam logic [7:0] DEV_ID = 8'h42;

   logic clk_50 = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic [15:0] command;
   logic finished;
   logic rom_resend, advance, sioc, siod_o, siod_oe, busy, done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [15:0] rom_mem [0:127];
   int          addr  = 0;
   logic [15:0] cmd_q = 16'hFFFF;

   logic [23:0] frames[$];
   logic [23:0] exp_frames[$];
   int          exp_adv;

   logic        p_sioc = 1'b1;
   logic        p_siod = 1'b1;
   bit          in_frame = 1'b0;
   int          bits = 0;
   logic [26:0] sh = '0;
   int          run_len = 0;
   int          adv_cnt = 0, resend_cnt = 0, toggles = 0;
   int          last_evt = -1, last_tog = 0, first_start = -1, first_adv = -1;
   int          exp_gap, exp_tog;
   logic        exp_oe;

   sccb_config_master #(
      .CLK_HZ(CLK_HZ), .SCCB_HZ(SCCB_HZ), .DEV_ID(DEV_ID),
      .DELAY_CYCLES(DLY), .SETTLE(SETTLE)
   ) dut (
      .clk_50(clk_50), .reset_n(reset_n), .start(start), .command(command),
      .finished(finished), .rom_resend(rom_resend), .advance(advance), .sioc(sioc),
      .siod_o(siod_o), .siod_oe(siod_oe), .busy(busy), .done(done)
   );

   always #5 clk_50 = ~clk_50;
   always @(posedge clk_50) cyc <= cyc + 1;

   // Register ROM: registered output, rewind and +1 address controls
   assign command  = cmd_q;
   assign finished = (cmd_q == 16'hFFFF);
   always @(posedge clk_50) begin
      if (rom_resend)   addr <= 0;
      else if (advance) addr <= addr + 1;
      cmd_q <= rom_mem[addr];
   end

   // Bus monitor: decodes frames and checks bit timing, oe masking and entry spacing
   always @(negedge clk_50) begin
      if (!reset_n) begin
         in_frame = 1'b0;
         last_evt = -1;
         run_len  = 0;
         p_sioc   = sioc;
         p_siod   = siod_o;
      end else begin
         if (rom_resend) begin
            resend_cnt++;
            last_evt = cyc;
            last_tog = toggles;
         end
         if (sioc !== p_sioc) toggles++;
         if (sioc && p_sioc && p_siod && !siod_o) begin
            n_tests++;
            if (in_frame !== 1'b0) begin
               n_fail++;
               $display("FAIL start_in_frame at bit %0d got=1 exp=0", bits);
            end
            in_frame = 1'b1;
            bits = 0;
            if (first_start < 0) first_start = cyc;
         end else if (sioc && p_sioc && !p_siod && siod_o) begin
            n_tests++;
            if (!in_frame || bits != 27) begin
               n_fail++;
               $display("FAIL stop_position got_bits=%0d exp=27 in_frame=%0b", bits, in_frame);
            end else begin
               frames.push_back({sh[26:19], sh[17:10], sh[8:1]});
            end
            in_frame = 1'b0;
         end
         if (in_frame && sioc && !p_sioc) begin
            if (bits >= 1 && bits < 27) begin
               n_tests++;
               if (run_len != 2 * Q) begin
                  n_fail++;
                  $display("FAIL sioc_low_len bit%0d got=%0d exp=%0d", bits, run_len, 2 * Q);
               end
            end
            if (bits < 27) begin
               sh = {sh[25:0], siod_o};
               exp_oe = !(bits == 8 || bits == 17 || bits == 26);
               n_tests++;
               if (siod_oe !== exp_oe) begin
                  n_fail++;
                  $display("FAIL siod_oe bit%0d got=%b exp=%b", bits, siod_oe, exp_oe);
               end
               bits++;
            end
         end
         if (in_frame && !sioc && p_sioc && bits >= 1) begin
            n_tests++;
            if (run_len != 2 * Q) begin
               n_fail++;
               $display("FAIL sioc_high_len bit%0d got=%0d exp=%0d", bits, run_len, 2 * Q);
            end
         end
         if (advance) begin
            adv_cnt++;
            if (first_adv < 0) first_adv = cyc;
            if (last_evt >= 0) begin
               exp_gap = (rom_mem[addr] == 16'hFFF0) ? DELAY_GAP : WRITE_GAP;
               exp_tog = (rom_mem[addr] == 16'hFFF0) ? 0 : 2 * 28;
               n_tests++;
               if (cyc - last_evt != exp_gap) begin
                  n_fail++;
                  $display("FAIL entry%0d_spacing got=%0d exp=%0d", addr, cyc - last_evt, exp_gap);
               end
               n_tests++;
               if (toggles - last_tog != exp_tog) begin
                  n_fail++;
                  $display("FAIL entry%0d_sioc_toggles got=%0d exp=%0d", addr, toggles - last_tog, exp_tog);
               end
            end
            last_evt = cyc;
            last_tog = toggles;
         end
         run_len = (sioc === p_sioc) ? run_len + 1 : 1;
         p_sioc  = sioc;
         p_siod  = siod_o;
      end
   end

   task automatic load_rom(input int n, input int delay_pct);
      logic [15:0] w;
      for (int i = 0; i < 128; i++) rom_mem[i] = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < delay_pct) begin
            w = 16'hFFF0;
         end else begin
            do w = 16'($urandom); while (w == 16'hFFF0 || w == 16'hFFFF);
         end
         rom_mem[i] = w;
      end
   endtask

   task automatic build_expected();
      exp_frames.delete();
      exp_adv = 0;
      for (int i = 0; i < 128 && rom_mem[i] != 16'hFFFF; i++) begin
         exp_adv++;
         if (rom_mem[i] != 16'hFFF0) exp_frames.push_back({DEV_ID, rom_mem[i]});
      end
   endtask

   task automatic run_rom();
      int i;
      frames.delete();
      adv_cnt = 0; resend_cnt = 0; first_start = -1; first_adv = -1;
      @(posedge clk_50); #1 start = 1'b1;
      @(posedge clk_50); #1 start = 1'b0;
      i = 0;
      while (done !== 1'b1 && i < 60000) begin
         @(posedge clk_50); #1;
         i++;
      end
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL run_timeout done=%b exp=1", done);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_50);
      #1;
      n_tests++;
      if ({sioc, siod_o, siod_oe, rom_resend, advance, busy, done} !== 7'b1110000) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b exp=1110000",
                  {sioc, siod_o, siod_oe, rom_resend, advance, busy, done});
      end
      reset_n = 1'b1;
      repeat (2) @(posedge clk_50);
   endtask

   task automatic test_single_frame();
      for (int i = 0; i < 128; i++) rom_mem[i] = 16'hFFFF;
      rom_mem[0] = 16'h1280;
      run_rom();
      n_tests++;
      if (resend_cnt != 1) begin n_fail++; $display("FAIL single_resend got=%0d exp=1", resend_cnt); end
      n_tests++;
      if (frames.size() != 1 || frames[0] !== 24'h421280) begin
         n_fail++;
         $display("FAIL single_frame got_n=%0d got=%h exp=421280", frames.size(),
                  (frames.size() > 0) ? frames[0] : 24'h0);
      end
      n_tests++;
      if (adv_cnt != 1) begin n_fail++; $display("FAIL single_adv_count got=%0d exp=1", adv_cnt); end
      n_tests++;
      if (first_adv - first_start != 117 * Q) begin
         n_fail++;
         $display("FAIL start_to_advance got=%0d exp=%0d", first_adv - first_start, 117 * Q);
      end
      n_tests++;
      if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL single_busy_done got=%b exp=01", {busy, done}); end
   endtask

   task automatic test_delay_entry();
      load_rom(3, 0);
      rom_mem[1] = 16'hFFF0;
      build_expected();
      run_rom();
      n_tests++;
      if (frames.size() != exp_frames.size()) begin
         n_fail++; $display("FAIL delay_frame_count got=%0d exp=%0d", frames.size(), exp_frames.size());
      end
      for (int i = 0; i < frames.size() && i < exp_frames.size(); i++) begin
         n_tests++;
         if (frames[i] !== exp_frames[i]) begin
            n_fail++; $display("FAIL delay_frame%0d got=%h exp=%h", i, frames[i], exp_frames[i]);
         end
      end
      n_tests++;
      if (adv_cnt != exp_adv) begin n_fail++; $display("FAIL delay_adv_count got=%0d exp=%0d", adv_cnt, exp_adv); end
   endtask

   task automatic test_start_ignored();
      load_rom(3, 0);
      build_expected();
      for (int pass = 0; pass < 2; pass++) begin
         fork
            run_rom();
            begin
               repeat (300) @(posedge clk_50);
               #1 start = 1'b1;
               @(posedge clk_50); #1 start = 1'b0;
            end
         join
         n_tests++;
         if (resend_cnt != 1) begin
            n_fail++; $display("FAIL ignored_start_resend pass%0d got=%0d exp=1", pass, resend_cnt);
         end
         n_tests++;
         if (frames.size() != exp_frames.size()) begin
            n_fail++; $display("FAIL ignored_frame_count pass%0d got=%0d exp=%0d", pass, frames.size(), exp_frames.size());
         end
         for (int i = 0; i < frames.size() && i < exp_frames.size(); i++) begin
            n_tests++;
            if (frames[i] !== exp_frames[i]) begin
               n_fail++; $display("FAIL ignored_frame%0d pass%0d got=%h exp=%h", i, pass, frames[i], exp_frames[i]);
            end
         end
      end
   endtask

   task automatic test_full_rom();
      load_rom(76, 12);
      build_expected();
      run_rom();
      n_tests++;
      if (frames.size() != exp_frames.size()) begin
         n_fail++; $display("FAIL full_frame_count got=%0d exp=%0d", frames.size(), exp_frames.size());
      end
      for (int i = 0; i < frames.size() && i < exp_frames.size(); i++) begin
         n_tests++;
         if (frames[i] !== exp_frames[i]) begin
            n_fail++; $display("FAIL full_frame%0d got=%h exp=%h", i, frames[i], exp_frames[i]);
         end
      end
      for (int i = 0; i < frames.size(); i++) begin
         n_tests++;
         if (frames[i][15:0] === 16'hFFFF) begin
            n_fail++; $display("FAIL full_ffff_sent frame%0d got=%h exp=not_ffff", i, frames[i]);
         end
      end
      n_tests++;
      if (adv_cnt != 76) begin n_fail++; $display("FAIL full_adv_count got=%0d exp=76", adv_cnt); end
      n_tests++;
      if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL full_busy_done got=%b exp=01", {busy, done}); end
   endtask

   task automatic test_reset_mid_bits();
      load_rom(2, 0);
      build_expected();
      @(posedge clk_50); #1 start = 1'b1;
      @(posedge clk_50); #1 start = 1'b0;
      for (int i = 0; i < 2000 && !(in_frame && bits >= 5); i++) @(posedge clk_50);
      n_tests++;
      if (!(in_frame && bits >= 5)) begin
         n_fail++; $display("FAIL midbits_reach got_bits=%0d exp>=5", bits);
      end
      @(posedge clk_50);
      #3 reset_n = 1'b0;
      #1;
      n_tests++;
      if ({sioc, siod_o, siod_oe, busy, rom_resend, advance} !== 6'b111000) begin
         n_fail++;
         $display("FAIL midbits_async_reset got=%b exp=111000", {sioc, siod_o, siod_oe, busy, rom_resend, advance});
      end
      repeat (3) @(posedge clk_50);
      #1 reset_n = 1'b1;
      run_rom();
      n_tests++;
      if (frames.size() != exp_frames.size()) begin
         n_fail++; $display("FAIL recover_frame_count got=%0d exp=%0d", frames.size(), exp_frames.size());
      end
      for (int i = 0; i < frames.size() && i < exp_frames.size(); i++) begin
         n_tests++;
         if (frames[i] !== exp_frames[i]) begin
            n_fail++; $display("FAIL recover_frame%0d got=%h exp=%h", i, frames[i], exp_frames[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom_mem[i] = 16'hFFFF;
      test_reset();
      test_single_frame();
      test_delay_entry();
      test_start_ignored();
      test_full_rom();
      test_reset_mid_bits();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
